video_timing_gen: RTL
=====================

// Module: video_timing_gen
// PURPOSE
//  Raster timing generator that sits directly upstream of the TMDS encoders (tmds_gen).
//  Free-running H/V counters produce sync, blanking and {vsync,hsync} control data for
//  tmds_gen, plus pixel coordinates for the frame-buffer/thermal-image read stage.
//  All outputs are registered and mutually cycle-aligned, and one pixel advances per
//  enabled i_clk cycle.
// PARAMETERS
//  H_ACTIVE   640  visible pixels per line
//  H_FP       16   horizontal front porch (pixels)
//  H_SYNC     96   hsync width (pixels)
//  H_BP       48   horizontal back porch (pixels)
//  V_ACTIVE   480  visible lines per frame
//  V_FP       10   vertical front porch (lines)
//  V_SYNC     2    vsync width (lines)
//  V_BP       33   vertical back porch (lines)
//  HSYNC_POL  0    asserted level of o_hsync (0 = active-low)
//  VSYNC_POL  0    asserted level of o_vsync (0 = active-low)
// PORTS
//  i_clk           in   1    pixel clock; single clock domain
//  i_rst           in   1    synchronous, active-high reset
//  i_en            in   1    advance enable; 0 freezes counters and all outputs
//  o_hsync         out  1    horizontal sync, polarity per HSYNC_POL
//  o_vsync         out  1    vertical sync, polarity per VSYNC_POL
//  o_control_data  out  2    {o_vsync,o_hsync}; connects to tmds_gen i_control_data (ch0)
//  o_blanking      out  1    1 outside active area; connects to tmds_gen i_blanking
//  o_x             out  XW   column, XW=$clog2(H_TOTAL), H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP
//  o_y             out  YW   row, YW=$clog2(V_TOTAL), V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP
//  o_line_start    out  1    1-cycle pulse when o_x==0
//  o_frame_start   out  1    1-cycle pulse when o_x==0 && o_y==0
//  o_rgb           out  24   test pattern {R,G,B}; see CONFIGURATION
// BEHAVIOUR
//  - Counters: h_cnt 0..H_TOTAL-1. At H_TOTAL-1 it wraps to 0 and v_cnt increments.
//    v_cnt wraps V_TOTAL-1 -> 0 on the same edge as the h wrap. Both counters advance
//    only on i_en=1.
//  - Output stage: registered decode of the counters. It updates only when i_en=1.
//    o_x/o_y equal the counter values that produced the current decode.
//  - Decode rules (comparisons are unsigned, at full XW/YW width):
//      * active: h<H_ACTIVE && v<V_ACTIVE, and o_blanking = !active.
//      * hsync asserted: H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
//      * vsync asserted: V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC.
//      * vsync changes only at h==0 boundaries.
//  - Reset (i_rst=1 at an edge): h_cnt=v_cnt=0.
//    Reset values of the outputs:
//      * o_x=0, o_y=0, o_blanking=1.
//      * o_hsync=~HSYNC_POL, o_vsync=~VSYNC_POL, o_control_data={~VSYNC_POL,~HSYNC_POL}.
//      * o_line_start=0, o_frame_start=0, o_rgb=0.
//  - Latency: the first enabled edge after reset release presents pixel (0,0), with
//    o_frame_start=1, o_line_start=1, o_blanking=0.
//  - Reset mid-frame: takes effect on that edge and overrides i_en. The raster restarts
//    at (0,0), and there is no partial-line completion.
//  - i_en=0: every output holds its previous value, and pulses are NOT repeated.
//    o_frame_start stays high only if it was high and is held; held pulses still count as
//    one event.
//  - Frame period = H_TOTAL*V_TOTAL enabled cycles. o_frame_start rises once per period.
//  - Parameter legality: all porch/sync values must be >= 1. H_ACTIVE and V_ACTIVE must be
//    >= 1. Elaboration error ($error) otherwise.
// CONFIGURATION
//  VTG_TEST_PATTERN_EN defined:
//    - o_rgb carries 8 vertical colour bars, each H_ACTIVE/8 pixels wide.
//    - Bar index = o_x/(H_ACTIVE/8), 0..7 -> {R,G,B} = {idx[2],idx[1],idx[0]} each
//      expanded to 8'hFF/8'h00.
//    - o_rgb is 0 while o_blanking=1 and is aligned with o_x.
//  VTG_TEST_PATTERN_EN undefined: o_rgb is tied to 24'h0, with no pattern logic.
// TESTING  (small params: H 8/2/3/3 -> H_TOTAL=16; V 4/1/2/1 -> V_TOTAL=8; POL=0; i_en=1)
//  1. rst 4 cycles, release -> first output: o_x=0,o_y=0,o_frame_start=1,o_blanking=0,
//     o_hsync=1,o_vsync=1.
//  2. Run 1 line -> o_blanking=1 for o_x 8..15. o_hsync=0 exactly at o_x 10,11,12.
//     o_line_start pulses every 16 cycles.
//  3. Run 2 frames -> o_vsync=0 exactly for o_y 5,6 (32 cycles each frame).
//     o_frame_start pulses exactly every 128 cycles. o_control_data=={o_vsync,o_hsync}
//     always.
//  4. Drop i_en for 5 cycles at o_x=5 -> all outputs frozen. On re-enable the next o_x=6,
//     and the frame period grows to 133 cycles.
//  5. Assert i_rst at (o_x=3,o_y=2) for 1 cycle -> reset values appear. The next cycle is
//     (0,0) with o_frame_start=1.
//  6. With VTG_TEST_PATTERN_EN (H_ACTIVE=16) -> o_rgb=0x000000 at x 0..1, 0x0000FF at 2..3,
//     ..., 0xFFFFFF at 14..15, and 0 in blanking. Without the macro -> o_rgb==0 always.

Source files
------------

// File: rtl/video_timing_gen.sv
// Raster timing generator feeding tmds_gen: free-running H/V counters with a registered decode stage.
// Optional colour-bar test pattern on o_rgb is built when VTG_TEST_PATTERN_EN is defined.
module video_timing_gen #(
   parameter int H_ACTIVE  = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_ACTIVE  = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter bit HSYNC_POL = 1'b0,
   parameter bit VSYNC_POL = 1'b0,
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int XW       = $clog2(H_TOTAL),
   localparam int YW       = $clog2(V_TOTAL)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_en,
   output logic          o_hsync,
   output logic          o_vsync,
   output logic [1:0]    o_control_data,
   output logic          o_blanking,
   output logic [XW-1:0] o_x,
   output logic [YW-1:0] o_y,
   output logic          o_line_start,
   output logic          o_frame_start,
   output logic [23:0]   o_rgb
);

   if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
       V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_params
      $error("video_timing_gen: active, porch and sync parameters must all be >= 1");
   end

   localparam logic [XW-1:0] H_LAST  = XW'(H_TOTAL - 1);
   localparam logic [XW-1:0] H_ACT_X = XW'(H_ACTIVE);
   localparam logic [XW-1:0] HS_BEG  = XW'(H_ACTIVE + H_FP);
   localparam logic [XW-1:0] HS_END  = XW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [YW-1:0] V_LAST  = YW'(V_TOTAL - 1);
   localparam logic [YW-1:0] V_ACT_Y = YW'(V_ACTIVE);
   localparam logic [YW-1:0] VS_BEG  = YW'(V_ACTIVE + V_FP);
   localparam logic [YW-1:0] VS_END  = YW'(V_ACTIVE + V_FP + V_SYNC);

   logic [XW-1:0] h_cnt_q, h_cnt_d;
   logic [YW-1:0] v_cnt_q, v_cnt_d;
   logic          h_last;

   logic [XW-1:0] x_q;
   logic [YW-1:0] y_q;
   logic          hsync_q, vsync_q, blank_q, line_q, frame_q;
   logic          active_d, hsync_d, vsync_d;

   always_comb begin
      h_last  = (h_cnt_q == H_LAST);
      h_cnt_d = h_last ? '0 : h_cnt_q + 1'b1;
      v_cnt_d = v_cnt_q;
      if (h_last) v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
   end

   // v_cnt only moves on the h wrap, so vsync can only toggle at x==0.
   always_comb begin
      active_d = (h_cnt_q < H_ACT_X) && (v_cnt_q < V_ACT_Y);
      hsync_d  = (h_cnt_q >= HS_BEG && h_cnt_q < HS_END) ? HSYNC_POL : ~HSYNC_POL;
      vsync_d  = (v_cnt_q >= VS_BEG && v_cnt_q < VS_END) ? VSYNC_POL : ~VSYNC_POL;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
         x_q     <= '0;
         y_q     <= '0;
         hsync_q <= ~HSYNC_POL;
         vsync_q <= ~VSYNC_POL;
         blank_q <= 1'b1;
         line_q  <= 1'b0;
         frame_q <= 1'b0;
      end else if (i_en) begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
         x_q     <= h_cnt_q;
         y_q     <= v_cnt_q;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
         blank_q <= ~active_d;
         line_q  <= (h_cnt_q == '0);
         frame_q <= (h_cnt_q == '0) && (v_cnt_q == '0);
      end
   end

`ifdef VTG_TEST_PATTERN_EN
   // Narrow rasters still get bars at least one pixel wide; the tail clamps to bar 7.
   localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

   logic [23:0] rgb_q, rgb_d;
   logic [2:0]  bar_idx;
   int unsigned bar_raw;

   always_comb begin
      bar_raw = 32'(h_cnt_q) / BAR_W;
      bar_idx = (bar_raw > 32'd7) ? 3'd7 : bar_raw[2:0];
      rgb_d   = '0;
      if (active_d) rgb_d = {{8{bar_idx[2]}}, {8{bar_idx[1]}}, {8{bar_idx[0]}}};
   end

   always_ff @(posedge i_clk) begin
      if (i_rst)     rgb_q <= '0;
      else if (i_en) rgb_q <= rgb_d;
   end

   assign o_rgb = rgb_q;
`else
   assign o_rgb = 24'h0;
`endif

   assign o_x            = x_q;
   assign o_y            = y_q;
   assign o_hsync        = hsync_q;
   assign o_vsync        = vsync_q;
   assign o_control_data = {vsync_q, hsync_q};
   assign o_blanking     = blank_q;
   assign o_line_start   = line_q;
   assign o_frame_start  = frame_q;

endmodule
